ap_ctrl_txn_profiler: RTL and testbench

AP_CTRL_TXN_PROFILER -- requirements
Module: ap_ctrl_txn_profiler

---
 rtl/ap_ctrl_txn_profiler.sv | 178 +++++++++++++++++
 tb/tb_ap_ctrl_txn_profiler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_ctrl_txn_profiler.sv
// Transaction profiler for an ap_ctrl_hs / ap_ctrl_chain handshake.
// Timestamps each accepted start, pairs it with the matching done in
// order, and streams (start, latency, interval) records through a FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | observing start/done events and producing records
// ST_DRAIN | finish seen; events ignored, queued records drain out
// ST_DONE  | run complete and record FIFO empty (terminal until reset)
module ap_ctrl_txn_profiler #(
    parameter int CNT_W     = 32,
    parameter int OST_DEPTH = 4,
    parameter int REC_DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [CNT_W-1:0] rec_start_ts,
    output logic [CNT_W-1:0] rec_latency,
    output logic [CNT_W-1:0] rec_interval,
    output logic [15:0]      txn_count,
    output logic [15:0]      drop_count,
    output logic             proto_err,
    output logic             all_done
);

    localparam int OST_AW = $clog2(OST_DEPTH);
    localparam int REC_AW = $clog2(REC_DEPTH);
    localparam logic [OST_AW:0] OST_FULL = OST_DEPTH[OST_AW:0];
    localparam logic [REC_AW:0] REC_FULL = REC_DEPTH[REC_AW:0];

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0]  now;
    logic              arm;

    logic [CNT_W-1:0]  ost_mem [OST_DEPTH];
    logic [OST_AW-1:0] ost_wr, ost_rd;
    logic [OST_AW:0]   ost_cnt;

    logic              pend_valid;
    logic [CNT_W-1:0]  pend_start, pend_lat;

    logic [CNT_W-1:0]  st_mem  [REC_DEPTH];
    logic [CNT_W-1:0]  lat_mem [REC_DEPTH];
    logic [CNT_W-1:0]  itv_mem [REC_DEPTH];
    logic [REC_AW-1:0] rec_wr, rec_rd;
    logic [REC_AW:0]   rec_cnt;

    logic              have_ref;
    logic [CNT_W-1:0]  last_start;

    logic start_ev, done_ev, ost_push, ost_pop, ost_full, ost_empty;
    logic rec_full, rec_rd_fire, rec_wr_en, rec_drop;
    logic [CNT_W-1:0] pend_itv;

    // Events only count while running; a done cannot be satisfied by a same-cycle start.
    assign start_ev  = (state == ST_RUN) && ap_start && arm;
    assign done_ev   = (state == ST_RUN) && ap_done && ap_continue;
    assign ost_full  = (ost_cnt == OST_FULL);
    assign ost_empty = (ost_cnt == '0);
    assign ost_push  = start_ev && !ost_full;
    assign ost_pop   = done_ev && !ost_empty;

    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign rec_valid   = (rec_cnt != '0);
    assign rec_full    = (rec_cnt == REC_FULL);
    assign rec_rd_fire = rec_valid && rec_ready;
    assign rec_wr_en   = pend_valid && (!rec_full || rec_rd_fire);
    assign rec_drop    = pend_valid && !rec_wr_en;
    assign pend_itv    = have_ref ? (pend_start - last_start) : '0;

    assign rec_start_ts = rec_valid ? st_mem[rec_rd]  : '0;
    assign rec_latency  = rec_valid ? lat_mem[rec_rd] : '0;
    assign rec_interval = rec_valid ? itv_mem[rec_rd] : '0;
    assign all_done     = (state == ST_DONE);

    // Timestamp counter, arm flag, outstanding queue and pending-record stage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            now        <= '0;
            arm        <= 1'b1;
            ost_wr     <= '0;
            ost_rd     <= '0;
            ost_cnt    <= '0;
            pend_valid <= 1'b0;
            pend_start <= '0;
            pend_lat   <= '0;
            proto_err  <= 1'b0;
        end else begin
            now <= now + 1'b1;
            if (ap_ready)
                arm <= 1'b1;
            else if (start_ev)
                arm <= 1'b0;
            if (ost_push)
                ost_wr <= ost_wr + 1'b1;
            if (ost_pop)
                ost_rd <= ost_rd + 1'b1;
            ost_cnt <= ost_cnt + {{OST_AW{1'b0}}, ost_push} - {{OST_AW{1'b0}}, ost_pop};
            pend_valid <= ost_pop;
            if (ost_pop) begin
                pend_start <= ost_mem[ost_rd];
                pend_lat   <= now - ost_mem[ost_rd];
            end
            if ((start_ev && ost_full) || (done_ev && ost_empty))
                proto_err <= 1'b1;
        end
    end

    // Outstanding-start storage.
    always_ff @(posedge clock) begin
        if (ost_push)
            ost_mem[ost_wr] <= now;
    end

    // Record FIFO pointers, interval reference and saturating counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rec_wr     <= '0;
            rec_rd     <= '0;
            rec_cnt    <= '0;
            have_ref   <= 1'b0;
            last_start <= '0;
            txn_count  <= '0;
            drop_count <= '0;
        end else begin
            if (rec_wr_en) begin
                rec_wr     <= rec_wr + 1'b1;
                have_ref   <= 1'b1;
                last_start <= pend_start;
                if (txn_count != 16'hFFFF)
                    txn_count <= txn_count + 16'd1;
            end
            if (rec_drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
            if (rec_rd_fire)
                rec_rd <= rec_rd + 1'b1;
            rec_cnt <= rec_cnt + {{REC_AW{1'b0}}, rec_wr_en} - {{REC_AW{1'b0}}, rec_rd_fire};
        end
    end

    // Record FIFO storage.
    always_ff @(posedge clock) begin
        if (rec_wr_en) begin
            st_mem[rec_wr]  <= pend_start;
            lat_mem[rec_wr] <= pend_lat;
            itv_mem[rec_wr] <= pend_itv;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    // Next-state: drain completes once nothing is stored or about to be written.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (finish) state_nxt = ST_DRAIN;
            ST_DRAIN: if (rec_cnt == '0 && !pend_valid) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_DONE;
            default:  state_nxt = ST_RUN;
        endcase
    end

endmodule

// File: tb/tb_ap_ctrl_txn_profiler.sv
// Directed bench for ap_ctrl_txn_profiler with a queue-based reference model
// and a per-cycle compare process, plus literal expectations per scenario.
module tb_ap_ctrl_txn_profiler;

    localparam int OST = 4;
    localparam int REC = 8;

    logic        clock, reset;
    logic        ap_start, ap_ready, ap_done, ap_continue, finish;
    logic        rec_valid, rec_ready;
    logic [31:0] rec_start_ts, rec_latency, rec_interval;
    logic [15:0] txn_count, drop_count;
    logic        proto_err, all_done;

    int n_checks = 0;
    int n_fail   = 0;

    ap_ctrl_txn_profiler #(.CNT_W(32), .OST_DEPTH(OST), .REC_DEPTH(REC)) dut (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .finish(finish),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_start_ts(rec_start_ts), .rec_latency(rec_latency), .rec_interval(rec_interval),
        .txn_count(txn_count), .drop_count(drop_count),
        .proto_err(proto_err), .all_done(all_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] st; logic [31:0] lat; } pend_t;
    typedef struct { logic [31:0] st; logic [31:0] lat; logic [31:0] itv; } rec_t;

    logic [31:0] m_now;
    bit          m_arm, m_perr, m_have_ref;
    logic [31:0] m_ref;
    int          m_phase;        // 0 running, 1 draining, 2 finished
    int          m_txn, m_drop;
    logic [31:0] m_ost[$];
    pend_t       m_pend[$];
    pend_t       m_wr[$];
    rec_t        m_fifo[$];
    bit          x_st, x_dn, x_xfer, x_empty;
    int          x_osz;
    logic [31:0] x_s;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_now = 0; m_arm = 1; m_perr = 0; m_have_ref = 0; m_ref = 0;
            m_phase = 0; m_txn = 0; m_drop = 0;
            m_ost = {}; m_pend = {}; m_fifo = {};
        end else begin
            x_xfer  = (m_fifo.size() != 0) && rec_ready;
            x_empty = (m_fifo.size() == 0) && (m_pend.size() == 0);
            // records from last cycle's dones land in the FIFO now
            m_wr = m_pend;
            m_pend = {};
            if (x_xfer) void'(m_fifo.pop_front());
            foreach (m_wr[i]) begin
                if (m_fifo.size() < REC) begin
                    m_fifo.push_back('{m_wr[i].st, m_wr[i].lat,
                                       m_have_ref ? m_wr[i].st - m_ref : 32'd0});
                    m_have_ref = 1; m_ref = m_wr[i].st;
                    if (m_txn < 65535) m_txn++;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end
            x_st = (m_phase == 0) && ap_start && m_arm;
            x_dn = (m_phase == 0) && ap_done && ap_continue;
            x_osz = m_ost.size();
            if (x_dn) begin
                if (x_osz > 0) begin
                    x_s = m_ost.pop_front();
                    m_pend.push_back('{x_s, m_now - x_s});
                end else m_perr = 1;
            end
            if (x_st) begin
                if (x_osz == OST) m_perr = 1;
                else m_ost.push_back(m_now);
            end
            if (ap_ready) m_arm = 1;
            else if (x_st) m_arm = 0;
            if (m_phase == 0 && finish) m_phase = 1;
            else if (m_phase == 1 && x_empty) m_phase = 2;
            m_now = m_now + 1;
        end
    end

    // Compare DUT against the model every cycle, away from the rising edge.
    always @(negedge clock) begin
        chk("m_rec_valid", {31'd0, rec_valid}, {31'd0, m_fifo.size() != 0});
        if (m_fifo.size() != 0) begin
            chk("m_start_ts", rec_start_ts, m_fifo[0].st);
            chk("m_latency",  rec_latency,  m_fifo[0].lat);
            chk("m_interval", rec_interval, m_fifo[0].itv);
        end
        chk("m_txn_count",  {16'd0, txn_count},  m_txn);
        chk("m_drop_count", {16'd0, drop_count}, m_drop);
        chk("m_proto_err",  {31'd0, proto_err},  {31'd0, m_perr});
        chk("m_all_done",   {31'd0, all_done},   {31'd0, m_phase == 2});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_now(input int t);
        for (int i = 0; i < 1000 && m_now != t; i++) tick();
        if (m_now != t) begin
            n_checks++; n_fail++;
            $display("FAIL wait_now: now %0d never reached %0d", m_now, t);
        end
    endtask

    task automatic start_at(input int t);
        wait_now(t);
        ap_start = 1; ap_ready = 1;
        tick();
        ap_start = 0; ap_ready = 0;
    endtask

    task automatic done_at(input int t);
        wait_now(t);
        ap_done = 1;
        tick();
        ap_done = 0;
    endtask

    task automatic do_reset();
        ap_start = 0; ap_ready = 0; ap_done = 0; finish = 0; rec_ready = 0;
        reset = 0;
        tick(); tick();
        reset = 1;
    endtask

    initial begin
        reset = 0; ap_continue = 1;
        ap_start = 0; ap_ready = 0; ap_done = 0; finish = 0; rec_ready = 0;
        #1;
        chk("rst_valid", {31'd0, rec_valid}, 0);
        chk("rst_txn",   {16'd0, txn_count}, 0);
        chk("rst_perr",  {31'd0, proto_err}, 0);
        chk("rst_done",  {31'd0, all_done},  0);
        chk("rst_data",  rec_start_ts, 0);

        // single transaction
        do_reset();
        start_at(10);
        done_at(25);
        wait_now(27);
        chk("t1_valid", {31'd0, rec_valid}, 1);
        chk("t1_start", rec_start_ts, 10);
        chk("t1_lat",   rec_latency, 15);
        chk("t1_itv",   rec_interval, 0);
        chk("t1_txn",   {16'd0, txn_count}, 1);
        rec_ready = 1; tick(); rec_ready = 0;
        chk("t1_empty", {31'd0, rec_valid}, 0);

        // pipelined
        do_reset();
        rec_ready = 1;
        start_at(10); start_at(14);
        done_at(30); wait_now(32);
        chk("t2_r0_start", rec_start_ts, 10);
        chk("t2_r0_lat",   rec_latency, 20);
        chk("t2_r0_itv",   rec_interval, 0);
        done_at(34); wait_now(36);
        chk("t2_r1_start", rec_start_ts, 14);
        chk("t2_r1_lat",   rec_latency, 20);
        chk("t2_r1_itv",   rec_interval, 4);
        chk("t2_perr",     {31'd0, proto_err}, 0);

        // backpressure
        do_reset();
        for (int k = 0; k < 10; k++) begin
            start_at(10 + 4 * k);
            done_at(12 + 4 * k);
        end
        wait_now(55);
        chk("t3_txn",   {16'd0, txn_count}, 8);
        chk("t3_drop",  {16'd0, drop_count}, 2);
        chk("t3_head",  rec_start_ts, 10);
        wait_now(60);
        chk("t3_stall_start", rec_start_ts, 10);
        chk("t3_stall_lat",   rec_latency, 2);
        rec_ready = 1;
        for (int i = 0; i < 8; i++) begin
            chk("t3_out_start", rec_start_ts, 10 + 4 * i);
            chk("t3_out_lat",   rec_latency, 2);
            chk("t3_out_itv",   rec_interval, (i == 0) ? 0 : 4);
            tick();
        end
        chk("t3_empty", {31'd0, rec_valid}, 0);
        rec_ready = 0;

        // done with nothing outstanding
        do_reset();
        done_at(10);
        wait_now(13);
        chk("t4_perr",  {31'd0, proto_err}, 1);
        chk("t4_valid", {31'd0, rec_valid}, 0);
        chk("t4_txn",   {16'd0, txn_count}, 0);

        // outstanding queue overflow
        do_reset();
        for (int k = 0; k < 4; k++) start_at(10 + 2 * k);
        wait_now(17);
        chk("t5_perr_at4", {31'd0, proto_err}, 0);
        start_at(18);
        wait_now(20);
        chk("t5_perr_at5", {31'd0, proto_err}, 1);

        // finish and drain
        do_reset();
        start_at(10); done_at(12);
        start_at(14); done_at(16);
        start_at(18);
        wait_now(20);
        finish = 1; tick(); finish = 0;
        done_at(22);
        wait_now(25);
        chk("t6_txn",   {16'd0, txn_count}, 2);
        chk("t6_perr",  {31'd0, proto_err}, 0);
        chk("t6_done0", {31'd0, all_done}, 0);
        rec_ready = 1;
        tick(); tick();
        chk("t6_drained", {31'd0, rec_valid}, 0);
        chk("t6_done1",   {31'd0, all_done}, 0);
        rec_ready = 0;
        tick();
        chk("t6_done2",   {31'd0, all_done}, 1);
        done_at(30);
        wait_now(33);
        chk("t6_late_txn", {16'd0, txn_count}, 2);
        chk("t6_late_val", {31'd0, rec_valid}, 0);
        chk("t6_sticky",   {31'd0, all_done}, 1);

        // reset mid-run
        do_reset();
        start_at(10); done_at(12);
        start_at(14); done_at(16);
        start_at(18); done_at(20);
        wait_now(25);
        chk("t7_pre_valid", {31'd0, rec_valid}, 1);
        chk("t7_pre_txn",   {16'd0, txn_count}, 3);
        reset = 0;
        #1;
        chk("t7_rst_valid", {31'd0, rec_valid}, 0);
        chk("t7_rst_txn",   {16'd0, txn_count}, 0);
        chk("t7_rst_drop",  {16'd0, drop_count}, 0);
        chk("t7_rst_data",  rec_start_ts, 0);
        tick(); tick();
        reset = 1;
        start_at(10); done_at(13);
        wait_now(15);
        chk("t7_start", rec_start_ts, 10);
        chk("t7_lat",   rec_latency, 3);
        chk("t7_itv",   rec_interval, 0);
        chk("t7_txn",   {16'd0, txn_count}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
